// File: rtl/asca_loader_pkg.sv
// asca_loader_pkg: shared definitions for the asca16 boot/run sequencer.
//   - state_e : sequencer states ST_IDLE..ST_ERR (encoding width ST_W)
//   - HALT_CYC_DEF / WDT_CYC_DEF : default halt and watchdog limits
//   - core_runs() / is_busy() : state decodes shared by the top and its users
package asca_loader_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_DONE   = 3'd2,
    ST_RUN    = 3'd3,
    ST_HALTED = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

  localparam int HALT_CYC_DEF = 4;
  localparam int WDT_CYC_DEF  = 65535;

  // The core is only let out of reset while it is meant to execute.
  function automatic logic core_runs(state_e s);
    return (s == ST_RUN) || (s == ST_HALTED);
  endfunction

  function automatic logic is_busy(state_e s);
    return (s == ST_LOAD) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/asca_loader_if.sv
// asca_loader_if: host program-word stream into the loader.
//   s_valid : host word valid            (master -> slave)
//   s_data  : program word, OP_W bits    (master -> slave)
//   s_last  : final word of the program  (master -> slave)
//   s_ready : loader accepts a word      (slave -> master)
// Handshake: a word transfers on a rising clk edge where s_valid and s_ready
// are both 1. s_data/s_last are only meaningful while s_valid is 1; the host
// may drop s_valid at any time without penalty, and s_ready never waits on
// s_valid.
interface asca_loader_if #(
  parameter int OP_W = 24
) ();
  logic            s_valid;
  logic [OP_W-1:0] s_data;
  logic            s_last;
  logic            s_ready;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/asca_halt_det.sv
// asca_halt_det: detects the branch-to-self halt idiom on the core PC.
//   clk, reset_n : clock, synchronous active-low reset
//   en           : core is in RUN; capture pc and compare
//   clr          : forget history (outside RUN); wins over en
//   pc           : core pc_out
//   halt_hit     : combinational; this cycle is the HALT_CYC-th consecutive
//                  equal-PC comparison
module asca_halt_det #(
  parameter int DATA_W   = 16,
  parameter int HALT_CYC = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] pc,
  output logic              halt_hit
);

  localparam logic [7:0] HIT_AT = 8'(HALT_CYC - 1);

  logic [DATA_W-1:0] pc_prev;
  logic              have_prev;
  logic [7:0]        same_cnt;
  logic              match;

  // No comparison on the first enabled cycle: pc_prev is not yet valid.
  assign match    = have_prev && (pc == pc_prev);
  assign halt_hit = en && match && (same_cnt == HIT_AT);

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      pc_prev   <= '0;
      have_prev <= 1'b0;
      same_cnt  <= '0;
    end else if (en) begin
      pc_prev   <= pc;
      have_prev <= 1'b1;
      if (match) begin
        if (same_cnt != 8'hFF) same_cnt <= same_cnt + 8'd1;
      end else begin
        same_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/asca_loader.sv
// asca_loader: boot/run sequencer for the asca16 core.
// Holds the core in reset while the host streams program words into
// instruction memory, releases it after the last word lands, then watches
// the core PC for the halt idiom.
// Optional watchdog: define ASCA_LOADER_WDT_EN.
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset
//   start_load          : pulse, begin a load (IDLE/HALTED/ERR)
//   stop_req            : pulse, abort/stop back to IDLE
//   host                : program-word stream (asca_loader_if.slave)
//   imem_wen/waddr/wdata: instruction memory write port (registered)
//   pc_in               : core pc_out
//   core_rst_n          : active-low reset to the core (registered)
//   busy                : LOAD or DONE
//   halted              : halt idiom detected
//   load_err            : sticky, program overflowed the memory
//   wdt_expired         : sticky, watchdog fired (0 without the watchdog)
//   word_cnt            : words accepted in the current/last load
//   dbg_state           : current sequencer state
module asca_loader
  import asca_loader_pkg::*;
#(
  parameter int OP_W     = 24,
  parameter int DATA_W   = 16,
  parameter int IMEM_AW  = 10,
  parameter int HALT_CYC = HALT_CYC_DEF,
  parameter int WDT_CYC  = WDT_CYC_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_load,
  input  logic               stop_req,
  asca_loader_if.slave       host,
  output logic               imem_wen,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [OP_W-1:0]    imem_wdata,
  input  logic [DATA_W-1:0]  pc_in,
  output logic               core_rst_n,
  output logic               busy,
  output logic               halted,
  output logic               load_err,
  output logic               wdt_expired,
  output logic [IMEM_AW:0]   word_cnt,
  output state_e             dbg_state
);

  localparam logic [IMEM_AW-1:0] PTR_MAX = '1;
  localparam logic [IMEM_AW:0]   CNT_MAX = {1'b1, {IMEM_AW{1'b0}}};

  state_e             state;
  state_e             state_nxt;
  logic [IMEM_AW-1:0] ptr;
  logic               hs;
  logic               load_start;
  logic               halt_hit;
  logic               wdt_fire;

  assign host.s_ready = (state == ST_LOAD) && !stop_req;
  assign hs           = host.s_valid && host.s_ready;
  assign dbg_state    = state;
  // Any entry into LOAD comes from an honoured start_load.
  assign load_start   = (state_nxt == ST_LOAD) && (state != ST_LOAD);

  asca_halt_det #(
    .DATA_W   (DATA_W),
    .HALT_CYC (HALT_CYC)
  ) u_halt_det (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (state == ST_RUN),
    .clr      (state != ST_RUN),
    .pc       (pc_in),
    .halt_hit (halt_hit)
  );

`ifdef ASCA_LOADER_WDT_EN
  localparam int                 WDT_W    = $clog2(WDT_CYC + 1);
  localparam logic [WDT_W-1:0]   WDT_LAST = WDT_W'(WDT_CYC - 1);

  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_flag;

  // Counts RUN cycles only; cleared everywhere else so it restarts on each
  // RUN entry and is frozen (cleared) once HALTED.
  always_ff @(posedge clk) begin
    if (!reset_n || (state != ST_RUN)) wdt_cnt <= '0;
    else                               wdt_cnt <= wdt_cnt + 1'b1;
  end

  // stop_req and a halt in the same cycle both outrank the watchdog.
  assign wdt_fire = (state == ST_RUN) && (wdt_cnt == WDT_LAST) &&
                    !stop_req && !halt_hit;

  always_ff @(posedge clk) begin
    if (!reset_n)        wdt_flag <= 1'b0;
    else if (load_start) wdt_flag <= 1'b0;
    else if (wdt_fire)   wdt_flag <= 1'b1;
  end

  assign wdt_expired = wdt_flag;
`else
  // WDT_CYC has no effect without the watchdog.
  assign wdt_fire    = 1'b0 & (WDT_CYC < 0);
  assign wdt_expired = 1'b0;
`endif

  // Next state. stop_req outranks everything outside IDLE; in IDLE it is
  // ignored so start_load wins a tie there.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start_load) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (stop_req) begin
          state_nxt = ST_IDLE;
        end else if (hs) begin
          if (host.s_last)         state_nxt = ST_DONE;
          else if (ptr == PTR_MAX) state_nxt = ST_ERR;
        end
      end
      // One cycle so the final imem write lands before the core wakes.
      ST_DONE: begin
        state_nxt = stop_req ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (stop_req)      state_nxt = ST_IDLE;
        else if (halt_hit) state_nxt = ST_HALTED;
        else if (wdt_fire) state_nxt = ST_IDLE;
      end
      ST_HALTED, ST_ERR: begin
        if (stop_req)        state_nxt = ST_IDLE;
        else if (start_load) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered outputs. core_rst_n/busy decode the next
  // state so they change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      imem_wen   <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      load_err   <= 1'b0;
      word_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      core_rst_n <= core_runs(state_nxt);
      busy       <= is_busy(state_nxt);
      imem_wen   <= hs;

      if (hs) begin
        imem_waddr <= ptr;
        imem_wdata <= host.s_data;
        ptr        <= ptr + 1'b1;
        if (word_cnt != CNT_MAX) word_cnt <= word_cnt + 1'b1;
        // Last slot filled and the program still wants more.
        if (!host.s_last && (ptr == PTR_MAX)) load_err <= 1'b1;
      end

      if ((state == ST_RUN) && (state_nxt == ST_HALTED)) halted <= 1'b1;
      if (state_nxt == ST_IDLE) halted <= 1'b0;

      if (load_start) begin
        ptr      <= '0;
        word_cnt <= '0;
        load_err <= 1'b0;
        halted   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_asca_loader.sv
// tb_asca_loader: self-checking bench for asca_loader (IMEM_AW=3, HALT_CYC=4,
// WDT_CYC=20). Inputs are driven 1 ns after posedge, outputs checked 2 ns
// after posedge; imem writes are checked at negedge against exp_q.
module tb_asca_loader;
  import asca_loader_pkg::*;

  localparam int OP_W     = 24;
  localparam int DATA_W   = 16;
  localparam int IMEM_AW  = 3;
  localparam int HALT_CYC = 4;
  localparam int WDT_CYC  = 20;
  localparam int SB_W     = IMEM_AW + OP_W;

  logic               clk;
  logic               reset_n;
  logic               start_load;
  logic               stop_req;
  logic               imem_wen;
  logic [IMEM_AW-1:0] imem_waddr;
  logic [OP_W-1:0]    imem_wdata;
  logic [DATA_W-1:0]  pc_in;
  logic               core_rst_n;
  logic               busy;
  logic               halted;
  logic               load_err;
  logic               wdt_expired;
  logic [IMEM_AW:0]   word_cnt;
  state_e             dbg_state;

  asca_loader_if #(.OP_W(OP_W)) host_bus ();

  asca_loader #(
    .OP_W(OP_W), .DATA_W(DATA_W), .IMEM_AW(IMEM_AW),
    .HALT_CYC(HALT_CYC), .WDT_CYC(WDT_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_load(start_load), .stop_req(stop_req),
    .host(host_bus), .imem_wen(imem_wen), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .pc_in(pc_in), .core_rst_n(core_rst_n),
    .busy(busy), .halted(halted), .load_err(load_err),
    .wdt_expired(wdt_expired), .word_cnt(word_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [SB_W-1:0] exp_q[$];
  logic [SB_W-1:0] sb_exp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (imem_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL imem_write: unexpected write addr=%0h data=%0h", imem_waddr, imem_wdata);
      end else begin
        sb_exp = exp_q.pop_front();
        chk("imem_write", 32'({imem_waddr, imem_wdata}), 32'(sb_exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start_load       = 1'b0;
    stop_req         = 1'b0;
    host_bus.s_valid = 1'b0;
    host_bus.s_last  = 1'b0;
    host_bus.s_data  = '0;
  endtask

  // Starts a load and streams n random words with random gaps. Returns in
  // the cycle after the final handshake with inputs idle.
  task automatic load_prog(input int n, input bit with_last, input int max_gap);
    logic [OP_W-1:0] w;
    int gap;
    start_load = 1'b1;
    cyc();
    start_load = 1'b0;
    for (int i = 0; i < n; i++) begin
      gap = int'($urandom_range(0, max_gap));
      for (int g = 0; g < gap; g++) begin
        host_bus.s_valid = 1'b0;
        #1;
        chk("load_gap_ready", 32'(host_bus.s_ready), 32'd1);
        cyc();
      end
      w = OP_W'($urandom);
      host_bus.s_valid = 1'b1;
      host_bus.s_data  = w;
      host_bus.s_last  = with_last && (i == n - 1);
      #1;
      chk("load_ready", 32'(host_bus.s_ready), 32'd1);
      exp_q.push_back({IMEM_AW'(i), w});
      cyc();
    end
    idle_in();
  endtask

  task automatic pulse_stop();
    stop_req = 1'b1;
    cyc();
    stop_req = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic               start, stop, valid, last;
    logic [OP_W-1:0]    data;
    logic [IMEM_AW-1:0] w_addr;
    logic               e_ready, e_wen, e_rst, e_busy;
    logic [IMEM_AW:0]   e_cnt;
    state_e             e_st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic sp, logic v, logic l, logic [OP_W-1:0] d,
                              logic [IMEM_AW-1:0] a, logic rdy, logic wen, logic rst,
                              logic bsy, logic [IMEM_AW:0] cnt, state_e s);
    vec_t r;
    r.start = st; r.stop = sp; r.valid = v; r.last = l; r.data = d; r.w_addr = a;
    r.e_ready = rdy; r.e_wen = wen; r.e_rst = rst; r.e_busy = bsy; r.e_cnt = cnt; r.e_st = s;
    return r;
  endfunction

  // ---------------- test ----------------
  logic [DATA_W-1:0] halt_pcs [8];
  logic [DATA_W-1:0] pc_tr [$];
  int  n, len, k;
  bit  ovf, win_eq;

  initial begin
    idle_in();
    reset_n = 1'b0;
    pc_in   = '0;
    repeat (3) cyc();
    #1;
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_wen", 32'(imem_wen), 32'd0);
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_wdt", 32'(wdt_expired), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_ready", 32'(host_bus.s_ready), 32'd0);
    reset_n = 1'b1;
    cyc();

    // Basic load of 5 words, one RUN cycle, stop.
    tbl.push_back(mk(1,0,0,0,24'h0,      0, 0,0,0,0, 0, ST_IDLE));
    tbl.push_back(mk(0,0,1,0,24'h000101, 0, 1,0,0,1, 0, ST_LOAD));
    tbl.push_back(mk(0,0,1,0,24'h000102, 1, 1,1,0,1, 1, ST_LOAD));
    tbl.push_back(mk(0,0,1,0,24'h000103, 2, 1,1,0,1, 2, ST_LOAD));
    tbl.push_back(mk(0,0,1,0,24'h000104, 3, 1,1,0,1, 3, ST_LOAD));
    tbl.push_back(mk(0,0,1,1,24'h000105, 4, 1,1,0,1, 4, ST_LOAD));
    tbl.push_back(mk(0,0,0,0,24'h0,      0, 0,1,0,1, 5, ST_DONE));
    tbl.push_back(mk(0,0,0,0,24'h0,      0, 0,0,1,0, 5, ST_RUN));
    tbl.push_back(mk(0,1,0,0,24'h0,      0, 0,0,1,0, 5, ST_RUN));
    tbl.push_back(mk(0,0,0,0,24'h0,      0, 0,0,0,0, 5, ST_IDLE));
    // Backpressure: start+stop in IDLE (start wins), gaps, stop mid-stream.
    tbl.push_back(mk(1,1,0,0,24'h0,      0, 0,0,0,0, 5, ST_IDLE));
    tbl.push_back(mk(0,0,1,0,24'h0000A1, 0, 1,0,0,1, 0, ST_LOAD));
    tbl.push_back(mk(0,0,0,0,24'h0,      0, 1,1,0,1, 1, ST_LOAD));
    tbl.push_back(mk(0,0,1,0,24'h0000A2, 1, 1,0,0,1, 1, ST_LOAD));
    tbl.push_back(mk(0,0,0,0,24'h0,      0, 1,1,0,1, 2, ST_LOAD));
    tbl.push_back(mk(0,1,1,0,24'h0000A3, 2, 0,0,0,1, 2, ST_LOAD));
    tbl.push_back(mk(0,0,0,0,24'h0,      0, 0,0,0,0, 2, ST_IDLE));
    tbl.push_back(mk(0,0,0,0,24'h0,      0, 0,0,0,0, 2, ST_IDLE));

    for (int i = 0; i < tbl.size(); i++) begin
      start_load       = tbl[i].start;
      stop_req         = tbl[i].stop;
      host_bus.s_valid = tbl[i].valid;
      host_bus.s_last  = tbl[i].last;
      host_bus.s_data  = tbl[i].data;
      pc_in            = DATA_W'(i);
      #1;
      chk("tbl_ready", 32'(host_bus.s_ready), 32'(tbl[i].e_ready));
      chk("tbl_wen", 32'(imem_wen), 32'(tbl[i].e_wen));
      chk("tbl_core_rst_n", 32'(core_rst_n), 32'(tbl[i].e_rst));
      chk("tbl_busy", 32'(busy), 32'(tbl[i].e_busy));
      chk("tbl_word_cnt", 32'(word_cnt), 32'(tbl[i].e_cnt));
      chk("tbl_state", 32'(dbg_state), 32'(tbl[i].e_st));
      if (tbl[i].valid && tbl[i].e_ready) exp_q.push_back({tbl[i].w_addr, tbl[i].data});
      cyc();
    end
    idle_in();

    // Overflow: 8 words without s_last into an 8-deep memory.
    load_prog(8, 1'b0, 0);
    #1;
    chk("ovf_state", 32'(dbg_state), 32'(ST_ERR));
    chk("ovf_load_err", 32'(load_err), 32'd1);
    chk("ovf_ready", 32'(host_bus.s_ready), 32'd0);
    chk("ovf_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("ovf_word_cnt", 32'(word_cnt), 32'd8);
    start_load = 1'b1;
    cyc();
    start_load = 1'b0;
    #1;
    chk("err_restart_state", 32'(dbg_state), 32'(ST_LOAD));
    chk("err_restart_load_err", 32'(load_err), 32'd0);
    chk("err_restart_cnt", 32'(word_cnt), 32'd0);
    stop_req = 1'b1;
    #1;
    chk("stop_masks_ready", 32'(host_bus.s_ready), 32'd0);
    cyc();
    stop_req = 1'b0;
    #1;
    chk("stop_load_state", 32'(dbg_state), 32'(ST_IDLE));

    // Halt detection on 0,1,2,3,3,3,3,3.
    halt_pcs = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3};
    load_prog(2, 1'b1, 0);
    #1;
    chk("done_state", 32'(dbg_state), 32'(ST_DONE));
    chk("done_core_rst_n", 32'(core_rst_n), 32'd0);
    cyc();
    for (int j = 0; j < 8; j++) begin
      pc_in = halt_pcs[j];
      #1;
      chk("halt_run_rst_n", 32'(core_rst_n), 32'd1);
      chk("halt_pre", 32'(halted), 32'd0);
      cyc();
    end
    #1;
    chk("halt_hit", 32'(halted), 32'd1);
    chk("halt_state", 32'(dbg_state), 32'(ST_HALTED));
    chk("halt_core_rst_n", 32'(core_rst_n), 32'd1);
    pc_in = 16'd9;
    cyc();
    #1;
    chk("halt_sticky", 32'(halted), 32'd1);
    pulse_stop();
    #1;
    chk("halt_stop_halted", 32'(halted), 32'd0);
    chk("halt_stop_rst_n", 32'(core_rst_n), 32'd0);
    chk("halt_stop_state", 32'(dbg_state), 32'(ST_IDLE));

    // Watchdog with incrementing PC.
    load_prog(1, 1'b1, 0);
    cyc();
`ifdef ASCA_LOADER_WDT_EN
    for (int j = 0; j < WDT_CYC; j++) begin
      pc_in = DATA_W'(j + 100);
      #1;
      chk("wdt_run_rst_n", 32'(core_rst_n), 32'd1);
      chk("wdt_pre", 32'(wdt_expired), 32'd0);
      cyc();
    end
    #1;
    chk("wdt_fired", 32'(wdt_expired), 32'd1);
    chk("wdt_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("wdt_state", 32'(dbg_state), 32'(ST_IDLE));
    start_load = 1'b1;
    cyc();
    start_load = 1'b0;
    #1;
    chk("wdt_cleared", 32'(wdt_expired), 32'd0);
    pulse_stop();
`else
    for (int j = 0; j < WDT_CYC + 5; j++) begin
      pc_in = DATA_W'(j + 100);
      #1;
      chk("nowdt_rst_n", 32'(core_rst_n), 32'd1);
      chk("nowdt_flag", 32'(wdt_expired), 32'd0);
      cyc();
    end
    pulse_stop();
`endif

    // Reset mid-load after 3 handshakes; the 4th word's write is dropped.
    start_load = 1'b1;
    cyc();
    start_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      host_bus.s_valid = 1'b1;
      host_bus.s_data  = OP_W'(24'h0C0 + i);
      exp_q.push_back({IMEM_AW'(i), OP_W'(24'h0C0 + i)});
      cyc();
    end
    host_bus.s_data = 24'h0000C3;
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    idle_in();
    #1;
    chk("mrst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("mrst_wen", 32'(imem_wen), 32'd0);
    chk("mrst_waddr", 32'(imem_waddr), 32'd0);
    chk("mrst_wdata", 32'(imem_wdata), 32'd0);
    chk("mrst_word_cnt", 32'(word_cnt), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_core_rst_n", 32'(core_rst_n), 32'd0);

    // Random programs and PC traces against the reference rules.
    for (int it = 0; it < 25; it++) begin
      n   = int'($urandom_range(1, 8));
      ovf = (n == 8) && ($urandom_range(0, 1) == 1);
      load_prog(n, !ovf, 2);
      #1;
      if (ovf) begin
        chk("rnd_ovf_state", 32'(dbg_state), 32'(ST_ERR));
        chk("rnd_ovf_err", 32'(load_err), 32'd1);
        chk("rnd_ovf_cnt", 32'(word_cnt), 32'd8);
        pulse_stop();
        #1;
        chk("rnd_ovf_stop", 32'(dbg_state), 32'(ST_IDLE));
      end else begin
        chk("rnd_done_state", 32'(dbg_state), 32'(ST_DONE));
        chk("rnd_done_cnt", 32'(word_cnt), 32'(n));
        chk("rnd_done_rst_n", 32'(core_rst_n), 32'd0);
        cyc();
        len = int'($urandom_range(4, 15));
        pc_tr.delete();
        pc_tr.push_back(DATA_W'($urandom_range(0, 3)));
        for (int j = 1; j < len; j++)
          pc_tr.push_back(($urandom_range(0, 1) == 1) ? pc_tr[j-1] : DATA_W'($urandom_range(0, 3)));
        // Halt is decided at the first cycle whose PC closes a window of
        // HALT_CYC+1 identical consecutive PCs.
        k = -1;
        for (int j = HALT_CYC; j < len; j++) begin
          win_eq = 1'b1;
          for (int m = 1; m <= HALT_CYC; m++)
            if (pc_tr[j-m] != pc_tr[j]) win_eq = 1'b0;
          if (win_eq && k < 0) k = j;
        end
        for (int j = 0; j < len; j++) begin
          pc_in = pc_tr[j];
          #1;
          chk("rnd_run_rst_n", 32'(core_rst_n), 32'd1);
          chk("rnd_halted", 32'(halted), 32'((k >= 0) && (k < j)));
          chk("rnd_state", 32'(dbg_state),
              ((k >= 0) && (k < j)) ? 32'(ST_HALTED) : 32'(ST_RUN));
          cyc();
        end
        #1;
        chk("rnd_halted_end", 32'(halted), 32'(k >= 0));
        if ((k >= 0) && ($urandom_range(0, 1) == 1)) begin
          start_load = 1'b1;
          cyc();
          start_load = 1'b0;
          #1;
          chk("rnd_reload_state", 32'(dbg_state), 32'(ST_LOAD));
          chk("rnd_reload_rst_n", 32'(core_rst_n), 32'd0);
          chk("rnd_reload_halted", 32'(halted), 32'd0);
          chk("rnd_reload_cnt", 32'(word_cnt), 32'd0);
        end
        pulse_stop();
        #1;
        chk("rnd_stop_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rnd_stop_rst_n", 32'(core_rst_n), 32'd0);
        chk("rnd_stop_halted", 32'(halted), 32'd0);
      end
    end

    repeat (3) cyc();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #300000;
    n_bad++;
    $display("FAIL timeout: bench did not finish in %0t", $time);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/asca_loader.md
Name: asca_loader

Overview:
- Boot/run sequencer for the asca16 core.
- Holds the core in reset while a host streams program words into instruction memory over a valid/ready interface.
- Releases core reset once loading completes, then watches pc_out to detect the halt idiom (branch-to-self).
- Sits between the host/test harness and the core's reset_n and instruction-memory write port.

Parameters:
- OP_W, 24: instruction word width; must match the core's op port.
- DATA_W, 16: data/PC width.
- IMEM_AW, 10: instruction memory address width; depth = 2**IMEM_AW.
- HALT_CYC, 4: consecutive equal-PC comparisons that declare halt; legal range 1..255.
- WDT_CYC, 65535: watchdog limit in RUN cycles; used only with the optional feature.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  synchronous, active-low reset.
- start_load  in  1  pulse; begins a load; honoured in IDLE, HALTED, ERR.
- stop_req  in  1  pulse; abort/stop; returns to IDLE.
- s_valid  in  1  host word valid.
- s_data  in  OP_W  host program word.
- s_last  in  1  final word of program.
- s_ready  out  1  loader accepts a word.
- imem_wen  out  1  instruction memory write enable.
- imem_waddr  out  IMEM_AW  write address.
- imem_wdata  out  OP_W  write data.
- pc_in  in  DATA_W  core pc_out.
- core_rst_n  out  1  synchronous active-low reset to the core.
- busy  out  1  state is LOAD or DONE.
- halted  out  1  halt detected.
- load_err  out  1  sticky: program overflowed the memory.
- wdt_expired  out  1  sticky: watchdog fired; tied 0 without the feature.
- word_cnt  out  IMEM_AW+1  words accepted in the current/last load.

Behaviour:
- Reset (reset_n=0 at a clk edge): state IDLE, all outputs 0, counters 0. Reset applies mid-operation with the same result; a pending imem write is dropped.
- States: IDLE, LOAD, DONE, RUN, HALTED, ERR. Encodings live in the package.
- core_rst_n=1 only in RUN and HALTED. It is registered from the next state, so it follows state transitions with no extra lag.
- IDLE: start_load -> LOAD; clears word_cnt, load_err, wdt_expired, halted, write pointer. stop_req is ignored. If start_load and stop_req arrive together, start_load wins.
- LOAD: s_ready = (state==LOAD) & ~stop_req, combinational.
  - Handshake at cycle t: imem_wen=1 at t+1 with imem_waddr=ptr, imem_wdata=s_data; ptr++ and word_cnt++.
  - Handshake with s_last: -> DONE.
  - Handshake at ptr = 2**IMEM_AW-1 without s_last: word is written, load_err=1, -> ERR.
  - stop_req: -> IDLE; no word accepted that cycle; load_err unchanged.
  - s_valid low: hold state, no timeout.
- DONE: exactly one cycle, so the last write lands before release; -> RUN. Handshake on last word at t gives core_rst_n=1 from t+2.
- RUN:
  - pc_prev is captured every cycle. Comparisons start on the 2nd RUN cycle.
  - same_cnt increments when pc_in==pc_prev and clears otherwise.
  - When same_cnt reaches HALT_CYC: -> HALTED, halted=1.
  - stop_req: -> IDLE (core reset reasserted next cycle); halted cleared.
- HALTED: core keeps running. stop_req -> IDLE. start_load -> LOAD with core_rst_n=0 next cycle.
- ERR: s_ready=0, core_rst_n=0. start_load -> LOAD; stop_req -> IDLE.
- stop_req has priority over halt detection in the same cycle.
- Simultaneous stop_req and start_load outside IDLE: stop_req wins.
- word_cnt saturates at 2**IMEM_AW.

Optional Feature:
- Macro: ASCA_LOADER_WDT_EN.
- Defined:
  - A RUN-cycle counter clears on entry to RUN.
  - On reaching WDT_CYC while in RUN: wdt_expired=1 (sticky until the next start_load or reset) and -> IDLE, resetting the core.
  - HALTED stops the counter.
- Undefined: no counter is synthesised and wdt_expired is a constant 0.

Decomposition:
- Shared package asca_loader_pkg:
  - state enum/localparams ST_IDLE..ST_ERR
  - state width
  - default HALT_CYC and WDT_CYC constants
- Sub-module asca_halt_det: pc_prev register plus same_cnt compare/counter, with enable and clear inputs and a halt_hit output.

Test Plan:
- Basic load/run: start_load, stream 5 words 0x000101..0x000105 with s_last on the 5th -> imem writes at addr 0..4; word_cnt=5; DONE one cycle; core_rst_n=1 two cycles after the last handshake.
- Backpressure: s_valid toggled 1-0-1 with a stop_req pulse between words -> the word during stop_req is not accepted; state IDLE; word_cnt=2; core_rst_n stays 0.
- Overflow: IMEM_AW=3, stream 8 words with no s_last -> 8 writes (addr 7 last); load_err=1; state ERR; s_ready=0; core_rst_n=0.
- Halt detect: HALT_CYC=4, pc_in sequence 0,1,2,3,3,3,3,3 -> halted=1 after the 4th equal comparison; core_rst_n stays 1; stop_req then gives halted=0 and core_rst_n=0.
- Reset mid-load: reset_n=0 during LOAD after 3 handshakes -> next cycle all outputs 0; imem_wen=0; state IDLE.
- Watchdog (ASCA_LOADER_WDT_EN, WDT_CYC=20): pc_in increments every cycle -> after 20 RUN cycles wdt_expired=1 and core_rst_n=0; without the macro, wdt_expired=0 throughout.
